// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one ROM read per cycle
// and buffers {pc, inst} for decode. Optional FETCHQ_BYPASS_EN forwards a return straight to decode.
module fetch_queue #(
  parameter int               DEPTH       = 4,
  parameter int               AW          = 8,
  parameter int               IW          = 9,
  parameter logic [AW-1:0]    RESET_PC    = 8'h00,
  parameter logic [IW-1:0]    HALT_OPCODE = 9'h1FF
) (
  input  logic                       CLK,
  input  logic                       start,
  output logic                       rom_en,
  output logic [AW-1:0]              rom_addr,
  input  logic [IW-1:0]              rom_data,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_addr,
  input  logic                       deq,
  output logic                       inst_valid,
  output logic [IW-1:0]              inst,
  output logic [AW-1:0]              inst_pc,
  output logic                       fetch_halted,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [AW+IW-1:0] mem [DEPTH];
  logic [PW-1:0]    headPtr;
  logic [PW-1:0]    tailPtr;
  logic [CW-1:0]    countReg;
  logic             inflight;
  logic [AW-1:0]    inflightPc;
  logic [AW-1:0]    fetchPc;
  logic             halted;
  logic [IW-1:0]    headInstReg;
  logic [AW-1:0]    headPcReg;

  logic             issue;
  logic             live;
  logic             isHalt;
  logic             bypass;
  logic             valid;
  logic             pop;
  logic             popQ;
  logic             pushQ;
  logic [CW-1:0]    countNext;
  logic [PW-1:0]    headPtrNext;
  logic [IW-1:0]    headInstNext;
  logic [AW-1:0]    headPcNext;

  // Credit rule: an issued read always has a free slot waiting for it.
  assign issue  = !start && !halted && !redirect &&
                  (({1'b0, countReg} + (CW+1)'(inflight)) < DEPTH_W);
  assign live   = inflight && !redirect && !start;
  assign isHalt = live && (rom_data == HALT_OPCODE);

`ifdef FETCHQ_BYPASS_EN
  assign bypass = live && (countReg == '0);
`else
  assign bypass = 1'b0;
`endif

  assign valid = (countReg != '0) || bypass;
  assign pop   = deq && valid && !redirect && !start;
  assign popQ  = pop && !bypass;
  assign pushQ = live && !(bypass && pop);

  // The head register is reloaded every cycle, forwarding the returning word
  // when it becomes the head, so inst/inst_pc hold their last value when empty.
  always_comb begin
    countNext    = countReg + CW'(pushQ) - CW'(popQ);
    headPtrNext  = headPtr + PW'(popQ);
    headInstNext = headInstReg;
    headPcNext   = headPcReg;
    if (countNext != '0) begin
      if (pushQ && (countReg == CW'(popQ)))
        {headPcNext, headInstNext} = {inflightPc, rom_data};
      else
        {headPcNext, headInstNext} = mem[headPtrNext];
    end else if (bypass && pop) begin
      {headPcNext, headInstNext} = {inflightPc, rom_data};
    end
  end

  always_ff @(posedge CLK) begin
    if (pushQ)
      mem[tailPtr] <= {inflightPc, rom_data};
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      headPtr     <= '0;
      tailPtr     <= '0;
      countReg    <= '0;
      inflight    <= 1'b0;
      inflightPc  <= '0;
      fetchPc     <= RESET_PC;
      halted      <= 1'b0;
      headInstReg <= '0;
      headPcReg   <= '0;
    end else if (redirect) begin
      headPtr  <= tailPtr;
      countReg <= '0;
      inflight <= 1'b0;
      fetchPc  <= redirect_addr;
      halted   <= 1'b0;
    end else begin
      headPtr     <= headPtrNext;
      tailPtr     <= tailPtr + PW'(pushQ);
      countReg    <= countNext;
      headInstReg <= headInstNext;
      headPcReg   <= headPcNext;
      // A read issued alongside the halt push is dropped on return.
      inflight    <= issue && !isHalt;
      if (issue) begin
        inflightPc <= fetchPc;
        fetchPc    <= fetchPc + AW'(1);
      end
      if (isHalt)
        halted <= 1'b1;
    end
  end

  assign rom_en       = issue;
  assign rom_addr     = fetchPc;
  assign inst_valid   = valid;
  assign inst         = bypass ? rom_data : headInstReg;
  assign inst_pc      = bypass ? inflightPc : headPcReg;
  assign fetch_halted = halted;
  assign count        = countReg;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run
// against a queue-based reference model of the prefetch rules.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [8:0] HALT = 9'h1FF;
`ifdef FETCHQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic       CLK = 1'b0;
  logic       start, redirect, deq;
  logic [7:0] redirect_addr;
  logic       rom_en, inst_valid, fetch_halted;
  logic [7:0] rom_addr, inst_pc;
  logic [8:0] rom_data, inst;
  logic [2:0] count;

  logic [8:0] romMem [256];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  mPc;
  bit          mHalted;
  bit          mPend;
  logic [7:0]  mPendPc;
  logic [16:0] mQ[$];
  logic [8:0]  mLastInst;
  logic [7:0]  mLastPc;

  // model expectations for the current cycle
  bit          eRomEn, eLive, eBypass, eValid, eHalt;
  logic [7:0]  eRomAddr, ePc;
  logic [8:0]  eInst;
  int          eCount;

  always #5 CLK = ~CLK;

  always @(posedge CLK) rom_data <= romMem[rom_addr];

  fetch_queue dut (
    .CLK(CLK), .start(start), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .redirect(redirect), .redirect_addr(redirect_addr),
    .deq(deq), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .fetch_halted(fetch_halted), .count(count)
  );

  task automatic drive(input bit s, input bit r, input logic [7:0] ra, input bit d);
    start = s; redirect = r; redirect_addr = ra; deq = d;
    @(negedge CLK);
    eRomEn   = !s && !mHalted && !r && ((mQ.size() + int'(mPend)) < DEPTH);
    eRomAddr = mPc;
    eLive    = mPend && !r && !s;
    eBypass  = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    eBypass  = eLive && (mQ.size() == 0);
`endif
    eValid = (mQ.size() > 0) || eBypass;
    if (mQ.size() > 0) {ePc, eInst} = mQ[0];
    else if (eBypass) begin ePc = mPendPc; eInst = romMem[mPendPc]; end
    else begin ePc = mLastPc; eInst = mLastInst; end
    eCount = mQ.size();
    eHalt  = mHalted;
  endtask

  task automatic advance();
    bit pop, isHalt;
    logic [8:0] ret;
    ret = romMem[mPendPc];
    if (start) begin
      mQ.delete(); mPend = 0; mPc = 8'h00; mHalted = 0; mLastInst = '0; mLastPc = '0;
    end else begin
      mLastInst = eInst; mLastPc = ePc;
      if (redirect) begin
        mQ.delete(); mPend = 0; mPc = redirect_addr; mHalted = 0;
      end else begin
        pop    = deq && eValid;
        isHalt = eLive && (ret == HALT);
        if (pop && !eBypass) void'(mQ.pop_front());
        if (eLive && !(eBypass && pop)) mQ.push_back({mPendPc, ret});
        if (isHalt) mHalted = 1;
        mPend = eRomEn && !isHalt;
        if (eRomEn) begin mPendPc = mPc; mPc = mPc + 8'd1; end
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < 2; i++) begin drive(1, 0, 8'h00, 0); advance(); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h00, 0);
      if (i == 2) begin
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        total++; if (inst !== 9'h000 || inst_pc !== 8'h00) begin bad++; $display("FAIL reset_head got=%h/%h exp=000/00", inst, inst_pc); end
        total++; if (fetch_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", fetch_halted); end
        total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
      end
      advance();
    end
  endtask

  task automatic test_stream();
    reset_dut();
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 8'h00, 1);
      if (k == 0) begin
        total++; if (rom_en !== 1'b1 || rom_addr !== 8'h00) begin bad++; $display("FAIL stream_first_issue got=%b/%h exp=1/00", rom_en, rom_addr); end
      end
      total++;
      if (k >= LAT) begin
        if (inst_valid !== 1'b1 || inst_pc !== 8'(k - LAT) || inst !== 9'(k - LAT)) begin
          bad++; $display("FAIL stream_head cyc=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst, 8'(k - LAT), 9'(k - LAT));
        end
      end else if (inst_valid !== 1'b0) begin
        bad++; $display("FAIL stream_latency cyc=%0d got valid=%b exp=0", k, inst_valid);
      end
      advance();
    end
  endtask

  task automatic test_full();
    logic [7:0] nextPc = 8'h00;
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 8'h00, 0);
      total++; if (count !== 3'(eCount)) begin bad++; $display("FAIL full_count cyc=%0d got=%0d exp=%0d", i, count, eCount); end
      if (i == 9) begin
        total++; if (count !== 3'd4 || rom_en !== 1'b0) begin bad++; $display("FAIL full_saturate got=%0d/%b exp=4/0", count, rom_en); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00) begin bad++; $display("FAIL full_head got=%b/%h exp=1/00", inst_valid, inst_pc); end
      end
      advance();
    end
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 8'h00, 1);
      if (inst_valid) begin
        total++; if (inst_pc !== nextPc) begin bad++; $display("FAIL full_resume got=%h exp=%h", inst_pc, nextPc); end
        nextPc++;
      end
      advance();
    end
    total++; if (nextPc < 8'd10) begin bad++; $display("FAIL full_progress got=%0d exp>=10", nextPc); end
  endtask

  task automatic test_redirect();
    int n = 0;
    reset_dut();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 8'h00, 0); advance(); end
    drive(0, 1, 8'h40, 1);
    total++; if (count !== 3'd3 || rom_en !== 1'b0) begin bad++; $display("FAIL redir_setup got=%0d/%b exp=3/0", count, rom_en); end
    advance();
    drive(0, 0, 8'h00, 1);
    total++; if (count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%0d/%b exp=0/0", count, inst_valid); end
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 8'h00, 1);
      if (inst_valid) begin
        total++; if (inst_pc !== 8'(8'h40 + n)) begin bad++; $display("FAIL redir_stream got=%h exp=%h", inst_pc, 8'(8'h40 + n)); end
        n++;
      end
      advance();
    end
    total++; if (n < 2) begin bad++; $display("FAIL redir_progress got=%0d exp>=2", n); end
  endtask

  task automatic test_halt();
    int n = 0;
    romMem[5] = HALT;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'h00, 1);
      if (inst_valid) begin
        total++;
        if (inst_pc !== 8'(n) || inst !== ((n == 5) ? HALT : 9'(n))) begin
          bad++; $display("FAIL halt_stream got=%h/%h exp=%h/%h", inst_pc, inst, 8'(n), (n == 5) ? HALT : 9'(n));
        end
        n++;
      end
      if (i == 15) begin
        total++; if (fetch_halted !== 1'b1 || rom_en !== 1'b0 || inst_valid !== 1'b0) begin
          bad++; $display("FAIL halt_stop got=%b/%b/%b exp=1/0/0", fetch_halted, rom_en, inst_valid);
        end
      end
      advance();
    end
    total++; if (n != 6) begin bad++; $display("FAIL halt_delivered got=%0d exp=6", n); end
    drive(0, 1, 8'h00, 1); advance();
    drive(0, 0, 8'h00, 1);
    total++; if (fetch_halted !== 1'b0 || rom_en !== 1'b1) begin bad++; $display("FAIL halt_clear got=%b/%b exp=0/1", fetch_halted, rom_en); end
    advance();
    romMem[5] = 9'h005;
  endtask

  task automatic test_wrap();
    int n = 0;
    reset_dut();
    drive(0, 1, 8'hFE, 1); advance();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 8'h00, 1);
      if (inst_valid) begin
        total++; if (inst_pc !== 8'(8'hFE + n) || inst !== {1'b0, 8'(8'hFE + n)}) begin
          bad++; $display("FAIL wrap_stream got=%h/%h exp=%h", inst_pc, inst, 8'(8'hFE + n));
        end
        n++;
      end
      advance();
    end
    total++; if (n < 4) begin bad++; $display("FAIL wrap_progress got=%0d exp>=4", n); end
  endtask

  task automatic test_midreset();
    int n = 0;
    reset_dut();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 8'h00, 0); advance(); end
    drive(1, 0, 8'h00, 0);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL midrst_setup got=%0d exp=3", count); end
    advance();
    drive(0, 0, 8'h00, 1);
    total++; if (count !== 3'd0 || inst_valid !== 1'b0 || rom_addr !== 8'h00 || rom_en !== 1'b1) begin
      bad++; $display("FAIL midrst_clear got=%0d/%b/%h/%b exp=0/0/00/1", count, inst_valid, rom_addr, rom_en);
    end
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 8'h00, 1);
      if (inst_valid) begin
        total++; if (inst_pc !== 8'(n)) begin bad++; $display("FAIL midrst_stream got=%h exp=%h", inst_pc, 8'(n)); end
        n++;
      end
      advance();
    end
    total++; if (n < 3) begin bad++; $display("FAIL midrst_progress got=%0d exp>=3", n); end
  endtask

  task automatic test_random();
    bit s, r, d;
    logic [7:0] ra;
    for (int a = 0; a < 256; a++)
      romMem[a] = ($urandom_range(0, 15) == 0) ? HALT : 9'($urandom_range(0, 510));
    reset_dut();
    for (int i = 0; i < 500; i++) begin
      s  = ($urandom_range(0, 63) == 0);
      r  = !s && ($urandom_range(0, 11) == 0);
      ra = 8'($urandom);
      d  = ($urandom_range(0, 9) < 6);
      drive(s, r, ra, d);
      if (!s) begin
        total++; if (rom_en !== eRomEn || (eRomEn && rom_addr !== eRomAddr)) begin
          bad++; $display("FAIL rand_fetch cyc=%0d got=%b/%h exp=%b/%h", i, rom_en, rom_addr, eRomEn, eRomAddr);
        end
        total++; if (inst_valid !== eValid || inst !== eInst || inst_pc !== ePc) begin
          bad++; $display("FAIL rand_head cyc=%0d got=%b/%h/%h exp=%b/%h/%h", i, inst_valid, inst, inst_pc, eValid, eInst, ePc);
        end
        total++; if (count !== 3'(eCount) || fetch_halted !== eHalt) begin
          bad++; $display("FAIL rand_status cyc=%0d got=%0d/%b exp=%0d/%b", i, count, fetch_halted, eCount, eHalt);
        end
      end
      advance();
    end
    for (int a = 0; a < 256; a++) romMem[a] = 9'(a);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) romMem[a] = 9'(a);
    start = 1'b1; redirect = 1'b0; redirect_addr = 8'h00; deq = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_halt();
    test_wrap();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
